// File: rtl/tone_decoder.sv
// tone_decoder: measures the rising-edge rate of an external tone over a
// fixed millisecond gate window and shows the detected note C4-B4.
module tone_decoder #(
    parameter int GATE_MS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic        sound_in,
    output logic [7:0]  led,
    output logic [2:0]  note,
    output logic [7:0]  freq_count,
    output logic        update
);

    localparam int MSW = (GATE_MS > 1) ? $clog2(GATE_MS) : 1;
    localparam logic [MSW-1:0] MS_LAST = MSW'(GATE_MS - 1);

    logic           sync1_q;
    logic           sync2_q;
    logic           prev_q;
    logic           edge_q;
    logic [15:0]    tick_q;
    logic [15:0]    tick_d;
    logic [MSW-1:0] ms_q;
    logic [MSW-1:0] ms_d;
    logic [7:0]     cnt_q;
    logic [7:0]     cnt_d;
    logic [7:0]     cnt_inc;
    logic [15:0]    tick_last;
    logic           tick_wrap;
    logic           win_end;
    logic [2:0]     cls_note;
    logic [6:0]     cls_seg;
    logic [7:0]     freq_q;
    logic [2:0]     note_q;
    logic [6:0]     seg_q;
    logic           dp_q;
    logic           update_q;

    // Two-flop synchronizer, previous-value flop and registered edge flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sound_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    // Millisecond timebase and saturating edge counter next-state
    always_comb begin
        tick_last = (ticks_per_milli == 16'd0) ? 16'd0
                                               : ticks_per_milli - 16'd1;
        tick_wrap = (tick_q >= tick_last);
        win_end   = tick_wrap && (ms_q >= MS_LAST);
        tick_d    = tick_wrap ? 16'd0 : tick_q + 16'd1;
        ms_d      = ms_q;
        if (tick_wrap) begin
            ms_d = win_end ? '0 : ms_q + 1'b1;
        end
        cnt_inc = cnt_q;
        if (edge_q && (cnt_q != 8'hFF)) begin
            cnt_inc = cnt_q + 8'd1;
        end
        cnt_d = win_end ? 8'd0 : cnt_inc;
    end

    // Counter registers; the window restarts on the cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 16'd0;
            ms_q   <= '0;
            cnt_q  <= 8'd0;
        end else begin
            tick_q <= tick_d;
            ms_q   <= ms_d;
            cnt_q  <= cnt_d;
        end
    end

    // Classify the count closing this window into a note and segment code
    always_comb begin
        cls_note = 3'd0;
        cls_seg  = 7'h40;
        unique case (1'b1)
            (cnt_inc >= 8'd24 && cnt_inc <= 8'd27): begin
                cls_note = 3'd1;
                cls_seg  = 7'h39;
            end
            (cnt_inc >= 8'd28 && cnt_inc <= 8'd31): begin
                cls_note = 3'd2;
                cls_seg  = 7'h5E;
            end
            (cnt_inc >= 8'd32 && cnt_inc <= 8'd33): begin
                cls_note = 3'd3;
                cls_seg  = 7'h79;
            end
            (cnt_inc >= 8'd34 && cnt_inc <= 8'd36): begin
                cls_note = 3'd4;
                cls_seg  = 7'h71;
            end
            (cnt_inc >= 8'd37 && cnt_inc <= 8'd41): begin
                cls_note = 3'd5;
                cls_seg  = 7'h3D;
            end
            (cnt_inc >= 8'd42 && cnt_inc <= 8'd46): begin
                cls_note = 3'd6;
                cls_seg  = 7'h77;
            end
            (cnt_inc >= 8'd47 && cnt_inc <= 8'd52): begin
                cls_note = 3'd7;
                cls_seg  = 7'h7C;
            end
            default: begin
                cls_note = 3'd0;
                cls_seg  = 7'h40;
            end
        endcase
    end

    // Latch the measurement, note, display and heartbeat at window end
    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q   <= 8'd0;
            note_q   <= 3'd0;
            seg_q    <= 7'h00;
            dp_q     <= 1'b0;
            update_q <= 1'b0;
        end else begin
            update_q <= win_end;
            if (win_end) begin
                freq_q <= cnt_inc;
                note_q <= cls_note;
                seg_q  <= cls_seg;
                dp_q   <= ~dp_q;
            end
        end
    end

    assign led        = {dp_q, seg_q};
    assign note       = note_q;
    assign freq_count = freq_q;
    assign update     = update_q;

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: randomized tone stimulus, window-level reference model
// and a scoreboard monitor checking every update pulse.
module tb_tone_decoder;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ticks_per_milli = 16'd10;
    logic        sound_in = 1'b0;
    logic [7:0]  led;
    logic [2:0]  note;
    logic [7:0]  freq_count;
    logic        update;

    always #5 clk = ~clk;

    tone_decoder #(.GATE_MS(G)) dut (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (ticks_per_milli),
        .sound_in        (sound_in),
        .led             (led),
        .note            (note),
        .freq_count      (freq_count),
        .update          (update)
    );

    typedef struct {
        int k;
        int cnt;
        int nt;
        int led;
    } exp_t;

    exp_t sb[$];
    int   dq[$];
    int   checks = 0;
    int   errors = 0;
    int   upd_cnt = 0;
    int   cyc = 0;

    int p_mode = 0, p_par = 0, p_ofs = 0, p_tpm = 10;
    int a_mode = 0, a_par = 0, a_ofs = 0, a_tpm = 10;
    int rst_req = 3;
    int tcount = 0;
    int prevlvl = 0;
    int mdp = 0;

    int segs [8] = '{'h40, 'h39, 'h5E, 'h79, 'h71, 'h3D, 'h77, 'h7C};

    function automatic int win_len(input int t);
        return G * ((t == 0) ? 1 : t);
    endfunction

    function automatic int classify(input int c);
        if (c >= 24 && c <= 27) return 1;
        if (c >= 28 && c <= 31) return 2;
        if (c >= 32 && c <= 33) return 3;
        if (c >= 34 && c <= 36) return 4;
        if (c >= 37 && c <= 41) return 5;
        if (c >= 42 && c <= 46) return 6;
        if (c >= 47 && c <= 52) return 7;
        return 0;
    endfunction

    // mode 0: constant level, 1: square tone of period par,
    // 2: exactly par pulses per window, 3: one pulse ending the window
    function automatic int level(input int m, input int par, input int ofs,
                                 input int t, input int pos, input int L);
        int s;
        case (m)
            0: return par;
            1: return (((t + ofs) % par) >= (par / 2)) ? 1 : 0;
            2: begin
                if (par == 0) return 0;
                s = (L - 8) / par;
                if (pos >= par * s) return 0;
                return ((pos % s) >= (s / 2)) ? 1 : 0;
            end
            default: return (pos >= L - 4) ? 1 : 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Driver and reference model: a pin rise seen at posedge k is counted
    // at posedge k+3; a window closes at every multiple of the window length
    always @(negedge clk) begin
        int   k, L, pos, lvl, n;
        exp_t e;
        tcount++;
        if (rst_req > 0) begin
            a_mode = p_mode;
            a_par  = p_par;
            a_ofs  = p_ofs;
            a_tpm  = p_tpm;
            rst_req--;
            rst = 1'b1;
            ticks_per_milli = 16'(a_tpm);
            prevlvl = 0;
            mdp = 0;
            dq.delete();
            L = win_len(a_tpm);
            sound_in = level(a_mode, a_par, a_ofs, tcount, 0, L) != 0;
        end else begin
            rst = 1'b0;
            k = cyc + 1;
            L = win_len(a_tpm);
            pos = (k - 1) % L;
            lvl = level(a_mode, a_par, a_ofs, tcount, pos, L);
            sound_in = (lvl != 0);
            if (lvl != 0 && prevlvl == 0) dq.push_back(k + 3);
            prevlvl = lvl;
            if (k % L == 0) begin
                n = 0;
                while (dq.size() > 0 && dq[0] <= k) begin
                    void'(dq.pop_front());
                    n++;
                end
                if (n > 255) n = 255;
                mdp = 1 - mdp;
                e.k   = k;
                e.cnt = n;
                e.nt  = classify(n);
                e.led = mdp * 128 + segs[e.nt];
                sb.push_back(e);
            end
        end
    end

    // Monitor: every update pulse must match the oldest expected window
    always @(negedge clk) begin
        exp_t e;
        if (update === 1'b1) begin
            upd_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_update: cyc=%0d freq=%0d note=%0d led=%02h, required no update",
                         cyc, freq_count, note, led);
            end else begin
                e = sb.pop_front();
                if (cyc != e.k || freq_count !== 8'(e.cnt) ||
                    note !== 3'(e.nt) || led !== 8'(e.led)) begin
                    errors++;
                    $display("FAIL window: got cyc=%0d freq=%0d note=%0d led=%02h, required cyc=%0d freq=%0d note=%0d led=%02h",
                             cyc, freq_count, note, led, e.k, e.cnt, e.nt, e.led);
                end
            end
        end else if (sb.size() > 0 && cyc != 0 && sb[0].k <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_update: got none at cyc=%0d, required update at cyc=%0d freq=%0d",
                     cyc, e.k, e.cnt);
        end
    end

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic chk_reset(input string name);
        checks++;
        if (led !== 8'h00 || note !== 3'd0 || freq_count !== 8'd0 ||
            update !== 1'b0) begin
            errors++;
            $display("FAIL %s: got led=%02h note=%0d freq=%0d update=%0d, required all 0",
                     name, led, note, freq_count, update);
        end
    endtask

    task automatic start(input int m, input int par, input int ofs,
                         input int t);
        @(posedge clk);
        p_mode  = m;
        p_par   = par;
        p_ofs   = ofs;
        p_tpm   = t;
        rst_req = 2;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset_outputs");
    endtask

    task automatic scenario(input string name, input int m, input int par,
                            input int ofs, input int t, input int nwin);
        int u0;
        start(m, par, ofs, t);
        u0 = upd_cnt;
        repeat (nwin * win_len(t) + 4) @(posedge clk);
        #1;
        chk(name, upd_cnt - u0, nwin);
    endtask

    int bnd_n   [4] = '{23, 24, 52, 53};
    int bnd_nt  [4] = '{0, 1, 7, 0};
    int bnd_seg [4] = '{'h40, 'h39, 'h7C, 'h40};

    initial begin
        int u0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("power_on_reset");
        repeat (2 * win_len(10) + 4) @(posedge clk);
        #1;
        chk("silent_updates", upd_cnt, 2);

        scenario("held_high", 0, 1, 0, 10, 2);

        for (int i = 0; i < 4; i++) begin
            scenario("boundary_updates", 2, bnd_n[i], 0, 10, 1);
            chk("boundary_freq", freq_count, bnd_n[i]);
            chk("boundary_note", note, bnd_nt[i]);
            chk("boundary_seg", led[6:0], bnd_seg[i]);
        end

        for (int i = 0; i < 6; i++) begin
            scenario("rand_count", 2, $urandom_range(0, 70), 0, 10, 1);
        end

        for (int i = 0; i < 4; i++) begin
            scenario("rand_tone", 1, $urandom_range(16, 60),
                     $urandom_range(0, 99), 10, 2);
        end

        scenario("saturation", 1, 2, 0, 10, 2);
        chk("sat_freq", freq_count, 255);
        chk("sat_note", note, 0);

        scenario("coincident", 3, 0, 0, 10, 3);
        chk("coincident_freq", freq_count, 1);

        scenario("tpm_zero", 1, $urandom_range(3, 9),
                 $urandom_range(0, 9), 0, 5);

        scenario("a4_tone", 1, 227, $urandom_range(0, 226), 100, 2);

        start(1, 384, 0, 100);
        u0 = upd_cnt;
        repeat (5000) @(posedge clk);
        start(1, 384, 0, 100);
        repeat (win_len(100) + 4) @(posedge clk);
        #1;
        chk("mid_reset_updates", upd_cnt - u0, 1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
